video_sync_gen: RTL and testbench

Decodes the raw pixel/line counters from `pixel_counters` into registered HDMI video timing: hsync, vsync, data-enable, active-area pixel coordinates, a frame strobe and a frame counter. It sits directly downstream of the timing counter and feeds the TMDS encoder stage. A built-in colour-bar source can be compiled in for bring-up. It also checks that the incoming counters are consistent and reports any violation through a sticky error flag.

---
 rtl/video_sync_gen.sv | 154 +++++++++++++++
 tb/tb_video_sync_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_sync_gen.sv
// HDMI timing decoder: turns raw pixel/line counters into registered syncs, DE, coordinates,
// frame strobe/count and a sticky counter-error flag. Colour bars: `VIDEO_SYNC_GEN_TEST_PATTERN_EN.
module video_sync_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic [11:0] h_count,
    input  logic [11:0] v_count,
    input  logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_strobe,
    output logic [7:0]  frame_cnt,
    output logic [23:0] rgb,
    output logic        timing_err
);

    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] H_TOTAL  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] V_TOTAL  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic in_range, h_act, v_act, hs_dec, vs_dec, de_dec, err_dec;

    // vsync window is lexicographic on (v,h) so its edges land on the hsync leading edge
    always_comb begin
        in_range = (h_count < H_TOTAL) && (v_count < V_TOTAL);
        h_act    = h_count < H_ACT;
        v_act    = v_count < V_ACT;
        de_dec   = in_range && h_act && v_act;
        hs_dec   = in_range && (h_count >= HS_START) && (h_count < HS_END);
        vs_dec   = in_range
                   && ((v_count > VS_START) || ((v_count == VS_START) && (h_count >= HS_START)))
                   && ((v_count < VS_END)   || ((v_count == VS_END)   && (h_count <  HS_START)));
        err_dec  = !in_range || (frame_start && ((h_count != 12'd0) || (v_count != 12'd0)));
    end

    logic        hs_s1_reg, vs_s1_reg, de_s1_reg, fs_s1_reg, err_s1_reg;
    logic [11:0] x_s1_reg, y_s1_reg;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1_reg  <= 1'b0;
            vs_s1_reg  <= 1'b0;
            de_s1_reg  <= 1'b0;
            fs_s1_reg  <= 1'b0;
            err_s1_reg <= 1'b0;
            x_s1_reg   <= '0;
            y_s1_reg   <= '0;
        end else begin
            hs_s1_reg  <= hs_dec;
            vs_s1_reg  <= vs_dec;
            de_s1_reg  <= de_dec;
            fs_s1_reg  <= frame_start;
            err_s1_reg <= err_dec;
            x_s1_reg   <= de_dec ? h_count : 12'd0;
            y_s1_reg   <= de_dec ? v_count : 12'd0;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync        <= ~HS_POL;
            vsync        <= ~VS_POL;
            de           <= 1'b0;
            x            <= '0;
            y            <= '0;
            frame_strobe <= 1'b0;
            frame_cnt    <= '0;
            timing_err   <= 1'b0;
        end else begin
            hsync        <= hs_s1_reg ? HS_POL : ~HS_POL;
            vsync        <= vs_s1_reg ? VS_POL : ~VS_POL;
            de           <= de_s1_reg;
            x            <= x_s1_reg;
            y            <= y_s1_reg;
            frame_strobe <= fs_s1_reg;
            frame_cnt    <= frame_cnt + 8'(fs_s1_reg);
            timing_err   <= timing_err | err_s1_reg;
        end
    end

`ifdef VIDEO_SYNC_GEN_TEST_PATTERN_EN
    localparam int          BAR_W    = H_ACTIVE / 8;
    localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

    logic [11:0] pix_reg, pix_next, pix_cur;
    logic [3:0]  bar_reg, bar_next, bar_cur, bar_s1_reg;

    // Bar index 8 means "past the last full bar" and decodes to black.
    always_comb begin
        pix_cur  = (h_count == 12'd0) ? 12'd0 : pix_reg;
        bar_cur  = (h_count == 12'd0) ? 4'd0  : bar_reg;
        pix_next = pix_cur;
        bar_next = bar_cur;
        if (h_act) begin
            if (pix_cur == BAR_LAST) begin
                pix_next = 12'd0;
                if (bar_cur != 4'd8)
                    bar_next = bar_cur + 4'd1;
            end else begin
                pix_next = pix_cur + 12'd1;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_reg    <= '0;
            bar_reg    <= '0;
            bar_s1_reg <= 4'd8;
            rgb        <= '0;
        end else begin
            pix_reg    <= pix_next;
            bar_reg    <= bar_next;
            bar_s1_reg <= bar_cur;
            if (!de_s1_reg) begin
                rgb <= 24'h000000;
            end else begin
                case (bar_s1_reg)
                    4'd0:    rgb <= 24'hFFFFFF;
                    4'd1:    rgb <= 24'hFFFF00;
                    4'd2:    rgb <= 24'h00FFFF;
                    4'd3:    rgb <= 24'h00FF00;
                    4'd4:    rgb <= 24'hFF00FF;
                    4'd5:    rgb <= 24'hFF0000;
                    4'd6:    rgb <= 24'h0000FF;
                    default: rgb <= 24'h000000;
                endcase
            end
        end
    end
`else
    assign rgb = 24'h000000;
`endif

endmodule

// File: tb/tb_video_sync_gen.sv
// Scoreboard bench for video_sync_gen: stimulus pushes expected outputs due two cycles later,
// a monitor pops and compares them; reset values are checked directly.
module tb_video_sync_gen;

    logic        pixel_clk = 1'b0;
    logic        rst_n;
    logic [11:0] h_count, v_count;
    logic        frame_start;
    logic        hsync, vsync, de, frame_strobe, timing_err;
    logic [11:0] x, y;
    logic [7:0]  frame_cnt;
    logic [23:0] rgb;

    video_sync_gen dut (
        .pixel_clk    (pixel_clk),
        .rst_n        (rst_n),
        .h_count      (h_count),
        .v_count      (v_count),
        .frame_start  (frame_start),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de),
        .x            (x),
        .y            (y),
        .frame_strobe (frame_strobe),
        .frame_cnt    (frame_cnt),
        .rgb          (rgb),
        .timing_err   (timing_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        int          due;
        int          id;
        logic [11:0] h, v;
        logic        hs, vs, de, fs, err, crgb;
        logic [11:0] x, y;
        logic [7:0]  fc;
        logic [23:0] rgb;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_txn = 0;
    logic [7:0]  exp_fc = 8'd0;
    logic        exp_err = 1'b0;
    logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always @(posedge pixel_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (txn %0d): got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    // Issue one counter sample; expected outputs are due two edges after it is captured.
    task automatic drive(input int h, input int v, input logic fs,
                         input logic ehs, input logic evs, input logic ede,
                         input logic set_err, input logic crgb, input logic [23:0] ergb);
        exp_t e;
        @(negedge pixel_clk);
        h_count = 12'(h);
        v_count = 12'(v);
        frame_start = fs;
        if (fs) exp_fc = exp_fc + 8'd1;
        if (set_err) exp_err = 1'b1;
        e.due  = cyc + 2;
        e.id   = n_txn++;
        e.h    = 12'(h);
        e.v    = 12'(v);
        e.hs   = ehs;
        e.vs   = evs;
        e.de   = ede;
        e.fs   = fs;
        e.err  = exp_err;
        e.x    = ede ? 12'(h) : 12'd0;
        e.y    = ede ? 12'(v) : 12'd0;
        e.fc   = exp_fc;
        e.crgb = crgb || !ede;
        e.rgb  = ede ? ergb : 24'h0;
        sb.push_back(e);
    endtask

    always @(posedge pixel_clk) begin
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            chk("latency",      mon_e.id, cyc, mon_e.due);
            chk("hsync",        mon_e.id, hsync, mon_e.hs);
            chk("vsync",        mon_e.id, vsync, mon_e.vs);
            chk("de",           mon_e.id, de, mon_e.de);
            chk("x",            mon_e.id, x, mon_e.x);
            chk("y",            mon_e.id, y, mon_e.y);
            chk("frame_strobe", mon_e.id, frame_strobe, mon_e.fs);
            chk("frame_cnt",    mon_e.id, frame_cnt, mon_e.fc);
            chk("timing_err",   mon_e.id, timing_err, mon_e.err);
            if (mon_e.crgb) chk("rgb", mon_e.id, rgb, mon_e.rgb);
            $display("txn %0d h=%0d v=%0d hs=%0b vs=%0b de=%0b x=%0d y=%0d fs=%0b fc=%0d err=%0b rgb=%06h",
                     mon_e.id, mon_e.h, mon_e.v, hsync, vsync, de, x, y, frame_strobe, frame_cnt,
                     timing_err, rgb);
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge pixel_clk);
            #2;
            n++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_hsync"},      -1, hsync, 1'b0);
        chk({tag, "_vsync"},      -1, vsync, 1'b0);
        chk({tag, "_de"},         -1, de, 1'b0);
        chk({tag, "_x"},          -1, x, 12'd0);
        chk({tag, "_y"},          -1, y, 12'd0);
        chk({tag, "_rgb"},        -1, rgb, 24'd0);
        chk({tag, "_strobe"},     -1, frame_strobe, 1'b0);
        chk({tag, "_frame_cnt"},  -1, frame_cnt, 8'd0);
        chk({tag, "_timing_err"}, -1, timing_err, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge pixel_clk);
        #2 rst_n = 1'b0;
        #1 reset_chk(tag);
        exp_fc  = 8'd0;
        exp_err = 1'b0;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] pat;
        rst_n = 1'b1;
        h_count = 12'd0;
        v_count = 12'd0;
        frame_start = 1'b0;
        #3 rst_n = 1'b0;
        #1 reset_chk("por");
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        rst_n = 1'b1;

        // Directed decode points around active area, hsync and vsync boundaries.
        //    h     v   fs  hs vs de err crgb rgb
        drive(0,    0,   1, 0, 0, 1, 0,  0,   24'h0);
        drive(1,    0,   0, 0, 0, 1, 0,  0,   24'h0);
        drive(1279, 719, 0, 0, 0, 1, 0,  0,   24'h0);
        drive(1280, 0,   0, 0, 0, 0, 0,  0,   24'h0);
        drive(0,    720, 0, 0, 0, 0, 0,  0,   24'h0);
        drive(1389, 0,   0, 0, 0, 0, 0,  0,   24'h0);
        drive(1390, 0,   0, 1, 0, 0, 0,  0,   24'h0);
        drive(1429, 0,   0, 1, 0, 0, 0,  0,   24'h0);
        drive(1430, 0,   0, 0, 0, 0, 0,  0,   24'h0);
        drive(1430, 724, 0, 0, 0, 0, 0,  0,   24'h0);
        drive(1389, 725, 0, 0, 0, 0, 0,  0,   24'h0);
        drive(1390, 725, 0, 1, 1, 0, 0,  0,   24'h0);
        drive(0,    726, 0, 0, 1, 0, 0,  0,   24'h0);
        drive(1649, 729, 0, 0, 1, 0, 0,  0,   24'h0);
        drive(1389, 730, 0, 0, 1, 0, 0,  0,   24'h0);
        drive(1390, 730, 0, 1, 0, 0, 0,  0,   24'h0);
        drive(1649, 749, 0, 0, 0, 0, 0,  0,   24'h0);

        // One contiguous line at v=0: hsync window, DE span and colour bars.
        for (int h = 0; h < 1650; h++) begin
`ifdef VIDEO_SYNC_GEN_TEST_PATTERN_EN
            pat = (h < 1280) ? bars[h / 160] : 24'h0;
`else
            pat = 24'h0;
`endif
            drive(h, 0, (h == 0), (h >= 1390 && h < 1430), 1'b0, (h < 1280), 1'b0, 1'b1, pat);
        end
        drain();

        // Mid-line reset while DE is high.
        drive(500, 10, 0, 0, 0, 1, 0, 0, 24'h0);
        drive(501, 10, 0, 0, 0, 1, 0, 0, 24'h0);
        drain();
        chk("pre_reset_de", -1, de, 1'b1);
        do_reset("mid");

        // 257 frame strobes: counter wraps through 255 back to 1.
        for (int i = 0; i < 257; i++) begin
            drive(0, 0, 1, 0, 0, 1, 0, 0, 24'h0);
            drive(1, 0, 0, 0, 0, 1, 0, 0, 24'h0);
        end
        drain();
        chk("frame_cnt_257", -1, frame_cnt, 8'd1);

        // Out-of-range counters force blanking and latch the error.
        drive(1700, 0,   0, 0, 0, 0, 1, 0, 24'h0);
        drive(1400, 800, 0, 0, 0, 0, 1, 0, 24'h0);
        drive(1390, 0,   0, 1, 0, 0, 0, 0, 24'h0);
        drive(100,  100, 0, 0, 0, 1, 0, 0, 24'h0);
        drain();
        repeat (5) @(negedge pixel_clk);
        chk("err_sticky", -1, timing_err, 1'b1);
        do_reset("err");

        // Misplaced frame_start still counts and flags an error.
        drive(5, 0, 1, 0, 0, 1, 1, 0, 24'h0);
        drive(6, 0, 0, 0, 0, 1, 0, 0, 24'h0);
        drain();
        chk("misplaced_fc",  -1, frame_cnt, 8'd1);
        chk("misplaced_err", -1, timing_err, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
